lcd_cmd_seq: RTL and testbench
==============================

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, max cycles to wait for controller busy after a command is issued.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port host_cmd, input, 4, command code from host (0 write, 1-4 shift, 5-7 max/min/avg, 8-11 rotate/mirror).
REQ-006 SHALL have port host_valid, input, 1, host_cmd valid.
REQ-007 SHALL have port host_ready, output, 1, sequencer accepts host_cmd this cycle.
REQ-008 SHALL have port cmd, output, 4, command to downstream LCD controller.
REQ-009 SHALL have port cmd_valid, output, 1, one-cycle command strobe to controller.
REQ-010 SHALL have port busy, input, 1, controller busy.
REQ-011 SHALL have port done, input, 1, controller write-back complete.
REQ-012 SHALL have port fifo_count, output, 5, current FIFO occupancy.
REQ-013 SHALL have port err_illegal, output, 1, sticky: illegal code (12-15) received.
REQ-014 SHALL have port err_timeout, output, 1, sticky: controller failed to raise busy within ACK_TIMEOUT.
REQ-015 SHALL have port seq_fin, output, 1, write command completed; sequencer halted.

Function
REQ-016 Handshake: transfer occurs when host_valid && host_ready; host_ready = !full && state != FIN.
REQ-017 Codes 12-15 SHALL be accepted (consume handshake), not enqueued, and set err_illegal.
REQ-018 FIFO SHALL be first-in first-out; simultaneous push and pop on non-empty FIFO leaves fifo_count unchanged; push into empty FIFO is poppable no earlier than next cycle.
REQ-019 FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, FIN.
REQ-020 IDLE -> ISSUE when FIFO non-empty && busy==0; else stay.
REQ-021 ISSUE: cmd = FIFO head, cmd_valid=1 for exactly this cycle, head popped; -> WAIT_DONE if cmd==0, else WAIT_ACK.
REQ-022 WAIT_ACK: -> IDLE when busy==1 is sampled; if ACK_TIMEOUT cycles pass without busy, set err_timeout and -> IDLE.
REQ-023 WAIT_DONE: -> FIN when done==1; no timeout.
REQ-024 FIN: terminal until reset; seq_fin=1, host_ready=0, cmd_valid=0; FIFO contents retained, never issued.
REQ-025 cmd SHALL hold its last issued value outside ISSUE; cmd_valid SHALL be 0 outside ISSUE.
REQ-026 Back-to-back issue SHALL be separated by at least one busy-high sample (or timeout), never two consecutive cmd_valid cycles.
REQ-027 Timeout counter SHALL be 4+ bits, cleared on entry to WAIT_ACK, saturating.

Reset
REQ-028 On reset: state IDLE, FIFO empty, fifo_count=0, cmd=0, cmd_valid=0, err_illegal=0, err_timeout=0, seq_fin=0; host_ready=1 from first cycle after release.
REQ-029 Reset mid-operation SHALL discard FIFO contents and any in-flight command tracking immediately (asynchronous).

Configuration
REQ-030 Macro LCD_CMD_SEQ_STAT_EN: when defined, SHALL add output issued_cnt (8 bits), count of cmd_valid pulses since reset, wrapping 255->0; when undefined, port and counter absent, all other behaviour identical.

Structure
REQ-031 Shared package lcd_pkg SHALL hold command code constants (CMD_WRITE=0 .. CMD_MIRROR_Y=11), the FSM state enum, and CMD_W=4.
REQ-032 FIFO SHALL be a separate sub-module lcd_cmd_fifo (push/pop/full/empty/count, parameter DEPTH).

Verification
REQ-033 Push 1,4,9 with busy low; controller model raises busy 1 cycle after each cmd_valid -> cmd_valid pulses carry 1,4,9 in order, err flags 0.
REQ-034 Push 13 then 2 -> err_illegal=1, only cmd=2 issued, fifo_count never exceeds 1.
REQ-035 Hold busy=1, push 9 commands with FIFO_DEPTH=8 -> host_ready=0 after 8th, fifo_count=8, 9th stalled until first issue.
REQ-036 Issue cmd 5, busy held low 15 cycles -> err_timeout=1 at cycle 15, FSM back to IDLE, next queued command issued.
REQ-037 Push 0 then 3; assert done 20 cycles later -> seq_fin=1, host_ready=0, cmd 3 never issued; assert reset -> all outputs to REQ-028 values.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: command codes, FSM states
// and the command width used by the sequencer and its FIFO.
package lcd_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE       = 4'd0,
    CMD_SHIFT_UP    = 4'd1,
    CMD_SHIFT_DOWN  = 4'd2,
    CMD_SHIFT_LEFT  = 4'd3,
    CMD_SHIFT_RIGHT = 4'd4,
    CMD_MAX         = 4'd5,
    CMD_MIN         = 4'd6,
    CMD_AVG         = 4'd7,
    CMD_ROT_CW      = 4'd8,
    CMD_ROT_CCW     = 4'd9,
    CMD_MIRROR_X    = 4'd10,
    CMD_MIRROR_Y    = 4'd11
  } lcd_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FIN
  } seq_state_e;

  // Codes above the last defined command (12-15) are rejected by the sequencer.
  function automatic logic is_legal_cmd(input logic [CMD_W-1:0] code);
    return code <= CMD_MIRROR_Y;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command FIFO for the LCD sequencer; DEPTH must be a power of two (2..16).
// The head is read straight from storage, so a word pushed into an empty FIFO
// becomes visible on the cycle after the push.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [CMD_W-1:0] data_i,
  input  logic             pop_i,
  output logic [CMD_W-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [4:0]       count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [4:0]       count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == 5'(DEPTH));
  assign empty_o = (count_q == 5'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: queues host commands and issues them one at a time to
// the LCD controller. Define LCD_CMD_SEQ_STAT_EN to add the issued_cnt output.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] host_cmd,
  input  logic             host_valid,
  output logic             host_ready,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  input  logic             busy,
  input  logic             done,
  output logic [4:0]       fifo_count,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic             seq_fin
`ifdef LCD_CMD_SEQ_STAT_EN
  ,
  output logic [7:0]       issued_cnt
`endif
);

  localparam int TMO_W = ($clog2(ACK_TIMEOUT + 1) > 4) ? $clog2(ACK_TIMEOUT + 1) : 4;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  seq_state_e       state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_timeout_q, err_timeout_d;

  logic             host_fire, fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_head;

  assign host_ready  = !fifo_full && (state_q != ST_FIN);
  assign host_fire   = host_valid && host_ready;
  assign fifo_push   = host_fire && is_legal_cmd(host_cmd);
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign seq_fin     = (state_q == ST_FIN);

  lcd_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (fifo_push),
    .data_i (host_cmd),
    .pop_i  (fifo_pop),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      tmo_q         <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      tmo_q         <= tmo_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // cmd shows the FIFO head only during ISSUE and otherwise holds the last
  // issued code; a write command waits for done instead of a busy handshake.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    tmo_d         = tmo_q;
    err_timeout_d = err_timeout_q;
    err_illegal_d = err_illegal_q | (host_fire && !is_legal_cmd(host_cmd));
    fifo_pop      = 1'b0;
    cmd_valid     = 1'b0;
    cmd           = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !busy) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cmd       = fifo_head;
        cmd_valid = 1'b1;
        fifo_pop  = 1'b1;
        cmd_d     = fifo_head;
        tmo_d     = '0;
        state_d   = (fifo_head == CMD_WRITE) ? ST_WAIT_DONE : ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (busy) begin
          state_d = ST_IDLE;
        end else if (tmo_q >= TMO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (done) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_FIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef LCD_CMD_SEQ_STAT_EN
  logic [7:0] issued_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q <= 8'd0;
    end else if (cmd_valid) begin
      issued_q <= issued_q + 8'd1;
    end
  end

  assign issued_cnt = issued_q;
`endif

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed bench for lcd_cmd_seq: a scoreboard queue holds accepted legal codes
// and a negedge monitor pops and compares them on every cmd_valid strobe.
module tb_lcd_cmd_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] host_cmd = 4'd0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done = 1'b0;
  logic [4:0] fifo_count;
  logic       err_illegal, err_timeout, seq_fin;

  logic       forceBusy = 1'b0;
  logic       ackBusy = 1'b0;
  logic       autoAck = 1'b1;
  logic       prevValid = 1'b0;
  int         ackCnt = 0;
  int         checks = 0;
  int         errors = 0;
  int         issueCount = 0;
  int         maxCount = 0;
  logic [3:0] expQ[$];

  assign busy = forceBusy | ackBusy;

  always #5 clk = ~clk;

  lcd_cmd_seq #(
    .FIFO_DEPTH (8),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count),
    .err_illegal(err_illegal),
    .err_timeout(err_timeout),
    .seq_fin    (seq_fin)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One host handshake; legal codes go into the scoreboard when accepted.
  task automatic applyStimulus(input logic [3:0] code);
    int n = 0;
    @(negedge clk);
    host_cmd   = code;
    host_valid = 1'b1;
    while (!host_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push_accept", host_ready, 1);
    if (host_ready && code < 4'd12) expQ.push_back(code);
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((expQ.size() != 0 || fifo_count != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, expQ.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic waitStrobe(input string tag);
    int n = 0;
    while (!cmd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, cmd_valid, 1);
  endtask

  // Controller model: busy rises half a cycle after each strobe and holds for
  // two samples, so the sequencer sees it on its first WAIT_ACK cycle.
  always @(negedge clk) begin
    if (reset) begin
      ackCnt    = 0;
      ackBusy   = 1'b0;
      prevValid = 1'b0;
    end else begin
      if (int'(fifo_count) > maxCount) maxCount = int'(fifo_count);
      if (cmd_valid) begin
        issueCount++;
        checkOutput("no_back_to_back", prevValid, 0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $error("[TB] FAIL unexpected_issue: observed cmd=%0d expected no strobe", cmd);
        end else begin
          checkOutput("issued_cmd", cmd, expQ.pop_front());
        end
        if (autoAck) ackCnt = 2;
      end else if (ackCnt > 0) begin
        ackCnt--;
      end
      ackBusy   = (ackCnt != 0);
      prevValid = cmd_valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap;
    int n;

    repeat (3) @(negedge clk);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_cmd", cmd, 0);
    checkOutput("rst_cmd_valid", cmd_valid, 0);
    checkOutput("rst_err_illegal", err_illegal, 0);
    checkOutput("rst_err_timeout", err_timeout, 0);
    checkOutput("rst_seq_fin", seq_fin, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_host_ready", host_ready, 1);

    $display("[TB] in-order issue of 1,4,9");
    applyStimulus(4'd1);
    applyStimulus(4'd4);
    applyStimulus(4'd9);
    waitDrain("order_drain");
    checkOutput("order_err_illegal", err_illegal, 0);
    checkOutput("order_err_timeout", err_timeout, 0);
    checkOutput("cmd_hold", cmd, 9);
    checkOutput("idle_cmd_valid", cmd_valid, 0);

    $display("[TB] illegal code 13 then 2");
    maxCount = 0;
    applyStimulus(4'd13);
    applyStimulus(4'd2);
    waitDrain("illegal_drain");
    checkOutput("illegal_flag", err_illegal, 1);
    checkOutput("illegal_max_count", maxCount, 1);

    $display("[TB] fill FIFO while busy");
    forceBusy = 1'b1;
    for (int i = 1; i <= 8; i++) applyStimulus(4'(i));
    checkOutput("full_count", fifo_count, 8);
    checkOutput("full_ready", host_ready, 0);
    @(negedge clk);
    host_cmd   = 4'd10;
    host_valid = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("stall_ready", host_ready, 0);
    checkOutput("stall_count", fifo_count, 8);
    forceBusy = 1'b0;
    n = 0;
    while (!host_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ninth_accept", host_ready, 1);
    if (host_ready) expQ.push_back(4'd10);
    @(negedge clk);
    host_valid = 1'b0;
    waitDrain("full_drain");

    $display("[TB] ack timeout on cmd 5");
    autoAck   = 1'b0;
    forceBusy = 1'b1;
    applyStimulus(4'd5);
    applyStimulus(4'd7);
    forceBusy = 1'b0;
    waitStrobe("tmo_strobe");
    // Strobe cycle plus 15 unanswered WAIT_ACK cycles before the flag sets.
    repeat (15) @(negedge clk);
    checkOutput("tmo_not_early", err_timeout, 0);
    @(negedge clk);
    checkOutput("tmo_flag", err_timeout, 1);
    autoAck = 1'b1;
    waitDrain("tmo_next_issue");
    checkOutput("tmo_sticky", err_timeout, 1);

    $display("[TB] write command halts sequencer");
    forceBusy = 1'b1;
    applyStimulus(4'd0);
    applyStimulus(4'd3);
    forceBusy = 1'b0;
    waitStrobe("write_strobe");
    checkOutput("write_cmd", cmd, 0);
    repeat (20) @(negedge clk);
    checkOutput("wait_done_fin", seq_fin, 0);
    checkOutput("wait_done_count", fifo_count, 1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    checkOutput("fin_seq_fin", seq_fin, 1);
    checkOutput("fin_host_ready", host_ready, 0);
    checkOutput("fin_cmd_valid", cmd_valid, 0);
    checkOutput("fin_cmd_hold", cmd, 0);
    snap = issueCount;
    repeat (10) @(negedge clk);
    checkOutput("fin_no_issue", issueCount, snap);
    checkOutput("fin_retained", fifo_count, 1);
    checkOutput("fin_queue_left", expQ.size(), 1);
    expQ.delete();

    $display("[TB] reset from FIN");
    reset = 1'b1;
    #1;
    checkOutput("rst2_fifo_count", fifo_count, 0);
    checkOutput("rst2_seq_fin", seq_fin, 0);
    checkOutput("rst2_err_illegal", err_illegal, 0);
    checkOutput("rst2_err_timeout", err_timeout, 0);
    checkOutput("rst2_cmd", cmd, 0);
    checkOutput("rst2_cmd_valid", cmd_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst2_host_ready", host_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
